// File: rtl/fact_pkg.sv
// Shared definitions for the factorial scheduler: FSM encoding, operand/result
// widths and the captured response record.
package fact_pkg;

  localparam int FACT_N_W   = 4;
  localparam int FACT_NF_W  = 32;
  localparam int FACT_N_MAX = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } fact_state_e;

  typedef struct packed {
    logic                 err;
    logic                 timeout;
    logic [FACT_NF_W-1:0] nf;
  } fact_resp_t;

endpackage : fact_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after rr_ptr
// (wrapping at NREQ) wins.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    gnt_valid = 1'b0;
    gnt_id    = '0;
    sum       = '0;
    idx       = '0;
    // Walk from the farthest slot back towards rr_ptr so the nearest one wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      idx = (sum >= (ID_W + 1)'(NREQ)) ? ID_W'(sum - (ID_W + 1)'(NREQ))
                                       : sum[ID_W-1:0];
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/fact_sched.sv
// Shares one factorial engine among NREQ requesters: round-robin grant, one
// start pulse per job, bounded wait for done/err, tagged response handshake.
module fact_sched
  import fact_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 64,
  localparam int ID_W    = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [FACT_N_W*NREQ-1:0] req_n,
  output logic [NREQ-1:0]          ack,
  output logic                     resp_valid,
  output logic [ID_W-1:0]          resp_id,
  output logic [FACT_NF_W-1:0]     resp_nf,
  output logic                     resp_err,
  output logic                     resp_timeout,
  input  logic                     resp_ready,
  output logic                     busy,
  output logic [FACT_N_W-1:0]      fact_n,
  output logic                     fact_go,
  input  logic                     fact_done,
  input  logic                     fact_err,
  input  logic [FACT_NF_W-1:0]     fact_nf
);

  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  fact_state_e           state_q,  state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       cur_id_q, cur_id_d;
  logic [FACT_N_W-1:0]   fact_n_q, fact_n_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  fact_resp_t            resp_q,   resp_d;

  logic                  gnt_valid;
  logic [ID_W-1:0]       gnt_id;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_id_d = cur_id_q;
    fact_n_d = fact_n_q;
    cnt_d    = cnt_q;
    resp_d   = resp_q;
    ack      = '0;
    fact_go  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          cur_id_d = gnt_id;
          for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == ID_W'(i)) fact_n_d = req_n[i*FACT_N_W +: FACT_N_W];
          end
          state_d = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        fact_go          = 1'b1;
        ack[cur_id_q]    = 1'b1;
        rr_ptr_d         = (cur_id_q == ID_W'(NREQ - 1)) ? '0 : cur_id_q + 1'b1;
        cnt_d            = '0;
        state_d          = ST_WAIT;
      end

      ST_WAIT: begin
        // Error outranks a simultaneous done; results are zeroed on any failure.
        if (fact_err) begin
          resp_d  = '{err: 1'b1, timeout: 1'b0, nf: '0};
          state_d = ST_RESP;
        end else if (fact_done) begin
          resp_d  = '{err: 1'b0, timeout: 1'b0, nf: fact_nf};
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_d  = '{err: 1'b1, timeout: 1'b1, nf: '0};
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      cur_id_q <= '0;
      fact_n_q <= '0;
      cnt_q    <= '0;
      resp_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_id_q <= cur_id_d;
      fact_n_q <= fact_n_d;
      cnt_q    <= cnt_d;
      resp_q   <= resp_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign resp_valid   = (state_q == ST_RESP);
  assign resp_id      = cur_id_q;
  assign resp_nf      = resp_q.nf;
  assign resp_err     = resp_q.err;
  assign resp_timeout = resp_q.timeout;
  assign fact_n       = fact_n_q;

endmodule : fact_sched

// File: tb/tb_fact_sched.sv
// Scoreboard bench for fact_sched: a behavioural engine stub, a round-robin
// job-order model, and a response monitor with randomized backpressure.
module tb_fact_sched;
  import fact_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int ID_W    = $clog2(NREQ);

  typedef struct {
    int     id;
    longint nf;
    bit     err;
    bit     to;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NREQ-1:0]          req;
  logic [FACT_N_W*NREQ-1:0] req_n;
  logic [NREQ-1:0]          ack;
  logic                     resp_valid;
  logic [ID_W-1:0]          resp_id;
  logic [FACT_NF_W-1:0]     resp_nf;
  logic                     resp_err;
  logic                     resp_timeout;
  logic                     resp_ready;
  logic                     busy;
  logic [FACT_N_W-1:0]      fact_n;
  logic                     fact_go;
  logic                     fact_done;
  logic                     fact_err;
  logic [FACT_NF_W-1:0]     fact_nf;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_ptr = 0;
  bit   eng_hang = 1'b0;
  int   eng_lat = 0;
  bit   force_stall = 1'b0;

  always #5 clk = ~clk;

  fact_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_n        (req_n),
    .ack          (ack),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_nf      (resp_nf),
    .resp_err     (resp_err),
    .resp_timeout (resp_timeout),
    .resp_ready   (resp_ready),
    .busy         (busy),
    .fact_n       (fact_n),
    .fact_go      (fact_go),
    .fact_done    (fact_done),
    .fact_err     (fact_err),
    .fact_nf      (fact_nf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // What the requester should see for operand n: n!, or an error for n>12,
  // or a timeout if the engine never answers.
  function automatic exp_t ref_job(input int id, input int n, input bit hang);
    exp_t   e;
    longint p = 1;
    e.id = id; e.err = 1'b0; e.to = 1'b0; e.nf = 0;
    if (hang) begin
      e.err = 1'b1; e.to = 1'b1;
    end else if (n > FACT_N_MAX) begin
      e.err = 1'b1;
    end else begin
      for (int i = 2; i <= n; i++) p = p * i;
      e.nf = p;
    end
    return e;
  endfunction

  // Engine stub: answers after a latency, flags n>12, and throws stray
  // done/err pulses whenever the scheduler is not waiting on it.
  initial begin
    logic [3:0] eng_n;
    int         eng_cnt;
    bit         job_active;
    exp_t       r;
    fact_done = 1'b0; fact_err = 1'b0; fact_nf = '0;
    job_active = 1'b0; eng_cnt = 0; eng_n = '0;
    forever begin
      @(posedge clk); #1;
      fact_done = 1'b0;
      fact_err  = 1'b0;
      if (!rst) begin
        job_active = 1'b0;
      end else if (fact_go) begin
        eng_n      = fact_n;
        job_active = !eng_hang;
        eng_cnt    = (eng_lat > 0) ? eng_lat : int'($urandom_range(1, 10));
      end else if (job_active) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          job_active = 1'b0;
          fact_nf    = $urandom();
          if (int'(eng_n) > FACT_N_MAX) begin
            fact_err  = 1'b1;
            fact_done = 1'($urandom_range(0, 1));
          end else begin
            r         = ref_job(0, int'(eng_n), 1'b0);
            fact_nf   = 32'(r.nf);
            fact_done = 1'b1;
          end
        end
      end else if ((!busy || resp_valid) && $urandom_range(0, 5) == 0) begin
        fact_done = 1'($urandom_range(0, 1));
        fact_err  = !fact_done;
        fact_nf   = $urandom();
      end
    end
  end

  // Response monitor: stalls, checks the response holds, then pops and compares.
  initial begin
    logic [ID_W-1:0]      s_id;
    logic [FACT_NF_W-1:0] s_nf;
    logic                 s_err, s_to;
    int                   stall;
    exp_t                 e;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && resp_valid) begin
        s_id = resp_id; s_nf = resp_nf; s_err = resp_err; s_to = resp_timeout;
        stall = force_stall ? 10 : int'($urandom_range(0, 3));
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check("hold_valid", 64'(resp_valid), 64'd1);
          check("hold_resp", 64'({resp_id, resp_nf, resp_err, resp_timeout}),
                64'({s_id, s_nf, s_err, s_to}));
          check("hold_no_ack", 64'(ack), 64'd0);
        end
        if (exp_q.size() == 0) begin
          expire("unexpected_resp");
        end else begin
          e = exp_q.pop_front();
          check("resp_id", 64'(s_id), 64'(e.id));
          check("resp_nf", 64'(s_nf), 64'(e.nf));
          check("resp_err", 64'(s_err), 64'(e.err));
          check("resp_timeout", 64'(s_to), 64'(e.to));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
      end
    end
  end

  // One cycle of requester behaviour: each requester drops its level on ack.
  task automatic step();
    @(negedge clk);
    req = req & ~ack;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 3000) begin
      step();
      k++;
    end
    if (k >= 3000) expire("idle_wait");
  endtask

  task automatic wait_acks();
    int k = 0;
    while (req != '0 && k < 5000) begin
      step();
      k++;
    end
    if (k >= 5000) expire("ack_wait");
  endtask

  // Raise a batch of requests together from idle; the order they get served
  // is simply ascending-cyclic from the model pointer.
  task automatic issue(input logic [NREQ-1:0] mask, input logic [FACT_N_W*NREQ-1:0] nv,
                       input bit hang, input int lat);
    int first = -1;
    int last  = 0;
    wait_idle();
    eng_hang = hang;
    eng_lat  = lat;
    for (int j = 0; j < NREQ; j++) begin
      int idx;
      idx = (model_ptr + j) % NREQ;
      if (mask[idx]) begin
        exp_q.push_back(ref_job(idx, int'(4'(nv >> (4 * idx))), hang));
        if (first < 0) first = idx;
        last = idx;
      end
    end
    model_ptr = (last + 1) % NREQ;
    req_n = nv;
    req   = mask;
    step();
    check("first_ack", 64'(ack), 64'(NREQ'(1) << first));
    wait_acks();
    wait_idle();
    eng_hang = 1'b0;
    eng_lat  = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst   = 1'b0;
    req   = '0;
    req_n = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_fact_go", 64'(fact_go), 64'd0);
    check("rst_fact_n", 64'(fact_n), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp", 64'({resp_valid, resp_id, resp_nf, resp_err, resp_timeout}), 64'd0);
    rst = 1'b1;

    // Arbitration from reset: 0,2,3 then the pointer wraps so 0 precedes 3.
    issue(4'b1101, 16'h6403, 1'b0, 0);
    issue(4'b1001, 16'h2001, 1'b0, 0);

    // Directed jobs: n=5 with a 6-cycle engine, max operand, zero, errors.
    issue(4'b0010, 16'h0050, 1'b0, 6);
    issue(4'b0100, 16'h0C00, 1'b0, 0);
    issue(4'b0001, 16'h0000, 1'b0, 0);
    issue(4'b1000, 16'hD000, 1'b0, 0);
    issue(4'b0010, 16'h00F0, 1'b0, 0);

    // Timeout with a 10-cycle stall; req[3] arrives mid-wait and must not be
    // acked until the stalled response is taken.
    wait_idle();
    eng_hang    = 1'b1;
    force_stall = 1'b1;
    exp_q.push_back(ref_job(1, 7, 1'b1));
    exp_q.push_back(ref_job(3, 9, 1'b0));
    model_ptr = 0;
    req_n = 16'h9070;
    req   = 4'b0010;
    step();
    check("to_ack", 64'(ack), 64'b0010);
    cyc = 0;
    while (!resp_valid && cyc < 200) begin
      step();
      cyc++;
      if (cyc == 5) req[3] = 1'b1;
    end
    check("timeout_latency", 64'(cyc), 64'(TIMEOUT + 1));
    eng_hang = 1'b0;
    wait_acks();
    force_stall = 1'b0;
    wait_idle();

    // Reset during WAIT: the job vanishes, a pending req[2] is served after.
    eng_hang = 1'b1;
    req_n = 16'h0430;
    req   = 4'b0010;
    step();
    check("rw_ack", 64'(ack), 64'b0010);
    repeat (4) step();
    req[2] = 1'b1;
    step();
    check("rw_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rw_busy", 64'(busy), 64'd0);
    check("rw_valid_go_ack", 64'({resp_valid, fact_go, ack}), 64'd0);
    check("rw_fact_n", 64'(fact_n), 64'd0);
    eng_hang  = 1'b0;
    model_ptr = 3;
    exp_q.push_back(ref_job(2, 4, 1'b0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step();
    check("rw_pending_ack", 64'(ack), 64'b0100);
    wait_acks();
    wait_idle();

    // Random batches, occasionally with a silent engine.
    for (int t = 0; t < 40; t++) begin
      issue(NREQ'($urandom_range(1, (1 << NREQ) - 1)), (FACT_N_W*NREQ)'($urandom()),
            ($urandom_range(0, 9) == 0), 0);
    end

    wait_idle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fact_sched

// File: doc/fact_sched.md
# fact_sched

Round-robin scheduler that shares one factorial engine among NREQ requesters. It captures one requester's `n`, pulses the engine's start, and waits for done or error, with a timeout. It then returns the result on a shared response channel tagged with the requester index. It sits between the software/peripheral request ports and the single `factorial` instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: max cycles waited for engine done/err before abort.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset. Asserted at 0; all state clears immediately.
- `req` input NREQ: request level per requester. Held until the matching `ack` pulse.
- `req_n` input 4*NREQ: operand per requester, slice i = `req_n[4i+3:4i]`. Stable while `req[i]`=1.
- `ack` output NREQ: one-cycle pulse when request i is accepted and its operand captured.
- `resp_valid` output 1: response available.
- `resp_id` output $clog2(NREQ): requester index of the response.
- `resp_nf` output 32: factorial result. Forced to 0 on error or timeout.
- `resp_err` output 1: engine error (n>12) or timeout.
- `resp_timeout` output 1: timeout abort.
- `resp_ready` input 1: consumer accepts the response.
- `busy` output 1: state ≠ IDLE.
- `fact_n` output 4: operand to engine, registered.
- `fact_go` output 1: one-cycle start pulse to engine.
- `fact_done` input 1: engine finished.
- `fact_err` input 1: engine error.
- `fact_nf` input 32: engine result.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- **IDLE**
  - If any `req` bit is set, the winner is chosen by round-robin starting at `rr_ptr`.
  - Capture `req_n` of the winner into `fact_n`, latch `cur_id`, then go to LAUNCH.
- **LAUNCH** (exactly 1 cycle)
  - `fact_go`=1 and `ack[cur_id]`=1.
  - `rr_ptr` ← `cur_id`+1 mod NREQ.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - `fact_err`=1 → `resp_err`=1, `resp_nf`=0, go to RESP. Err takes priority when it coincides with done.
  - Else `fact_done`=1 → `resp_nf` ← `fact_nf`, `resp_err`=0, go to RESP.
  - Else if the counter reaches TIMEOUT−1 → `resp_err`=1, `resp_timeout`=1, `resp_nf`=0, go to RESP.
  - Else increment the counter.
- **RESP**
  - `resp_valid`=1; all `resp_*` outputs are stable.
  - `resp_ready`=1 → go to IDLE, `resp_valid` drops next cycle.
- `fact_done`/`fact_err` are ignored outside WAIT.
- Requests arriving in non-IDLE states wait; `req` is never dropped without an `ack`.
- Operand width is 4 bits. The scheduler does no range check; the engine flags n>12.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0.
  - `ack`=0, `fact_go`=0, `fact_n`=0, `busy`=0.
  - `resp_valid`=0, `resp_id`=0, `resp_nf`=0, `resp_err`=0, `resp_timeout`=0.
- `req` sampled at edge T in IDLE → `fact_go` and `ack` high during cycle T+1.
- WAIT is entered at T+2.
- Engine done sampled at edge D → `resp_valid`=1 from D+1.
- `resp_ready` sampled with `resp_valid` at edge R → IDLE at R+1. A new grant is possible at R+1's edge, so the earliest next `fact_go` is at R+2.
- Minimum turnaround per job: 4 cycles plus engine latency.
- Round-robin fairness: with all requests asserted, the grant order is 0,1,2,…,NREQ−1,0,…
- Timeout: if no done/err occurs, `resp_valid` rises exactly TIMEOUT cycles after WAIT entry.
- Reset asserted mid-operation: outputs return to reset values asynchronously. The in-flight job is lost with no response. The engine is reset by the same system reset.

## Structure
- Shared package `fact_pkg`:
  - State encoding: IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2, RESP=2'd3.
  - `FACT_N_W`=4, `FACT_NF_W`=32, `FACT_N_MAX`=12.
- Sub-module `rr_arbiter`:
  - Combinational: inputs `req`[NREQ] and `rr_ptr`; outputs `gnt_valid` and `gnt_id`.
  - Rotating priority, lowest index wins after the pointer.
- The rest lives in `fact_sched`: FSM, counter, capture registers.

## Test plan
- **Single job:** `req[1]`=1, n=5, engine model done after 6 cycles → `ack[1]` pulse at T+1; response `resp_id`=1, `resp_nf`=120, `resp_err`=0.
- **Max operand:** n=12 → `resp_nf`=479001600. Also n=0 → `resp_nf`=1.
- **Error:** n=13, engine err → `resp_err`=1, `resp_nf`=0, `resp_timeout`=0.
- **Arbitration:** `req[0]`, `req[2]`, `req[3]` asserted together from reset → service order 0,2,3. Then re-asserting `req[0]` and `req[3]` gives 0 before 3, since `rr_ptr` wrapped to 0.
- **Timeout and backpressure:** the engine stub never asserts done → `resp_timeout`=1, `resp_err`=1 exactly 64 cycles after WAIT entry. `resp_ready` held low for 10 cycles → `resp_valid` and all `resp_*` outputs stay constant and no new `ack` is issued.
- **Reset mid-WAIT:** `rst`=0 during WAIT → `busy`, `resp_valid` and `fact_go` go to 0 immediately. After release, a pending `req[2]` is accepted normally.
